pztb_reset_gen: RTL

//  Reset sequencer driven by the bench clock generator's clk output.

---
 rtl/pztb_reset_gen_pkg.sv | 19 +
 rtl/pztb_reset_gen_synchronizer.sv | 37 +++
 rtl/pztb_reset_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pztb_reset_gen_pkg.sv
// -----------------------------------------------------------------------------
// pztb_reset_gen_pkg
//   Shared types for the bench reset sequencer.
//   - state_e : sequencer states (assert all, staggered release, done)
//   - count_t : default-width cycle counter type
// -----------------------------------------------------------------------------
package pztb_reset_gen_pkg;

    localparam int DEFAULT_COUNT_WIDTH = 16;

    typedef logic [DEFAULT_COUNT_WIDTH-1:0] count_t;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/pztb_reset_gen_synchronizer.sv
// -----------------------------------------------------------------------------
// pztb_reset_synchronizer
//   Reset synchronizer: assertion is asynchronous, deassertion is delayed by
//   SYNC_STAGES rising edges of clk.
//   Ports:
//     clk     in   clock
//     rst_n   in   asynchronous active-low reset
//     o_rst_n out  synchronized active-low reset
// -----------------------------------------------------------------------------
module pztb_reset_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_rst_n
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_rst_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pztb_reset_gen.sv
// -----------------------------------------------------------------------------
// pztb_reset_gen
//   Bench reset sequencer. Holds NUM_RESETS active-low resets low for N cycles,
//   then releases them one by one in index order, STAGGER_CYCLES apart.
//   Ports:
//     clk              in   clock
//     rst_n            in   asynchronous active-low power-on reset
//     i_start          in   1-cycle request to begin a new reset sequence
//     i_assert_cycles  in   assert length; 0 selects ASSERT_CYCLES
//     o_reset_n        out  active-low resets to the DUT
//     o_busy           out  sequence in progress
//     o_done           out  all resets released, held until next sequence
// -----------------------------------------------------------------------------
module pztb_reset_gen
    import pztb_reset_gen_pkg::*;
#(
    parameter int NUM_RESETS     = 2,
    parameter int ASSERT_CYCLES  = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int COUNT_WIDTH    = DEFAULT_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic [COUNT_WIDTH-1:0] i_assert_cycles,
    output logic [NUM_RESETS-1:0]  o_reset_n,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [COUNT_WIDTH-1:0] STAG_LAST =
        COUNT_WIDTH'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
    // With a single output or no stagger, everything releases on the ASSERT exit.
    localparam bit ALL_AT_ONCE = (STAGGER_CYCLES == 0) || (NUM_RESETS == 1);

    logic fsm_rst_n;

    pztb_reset_synchronizer #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_rst_n(fsm_rst_n)
    );

    state_e                  state_q, state_d;
    logic [COUNT_WIDTH-1:0]  cnt_q,   cnt_d;
    logic [COUNT_WIDTH-1:0]  n_q,     n_d;
    logic                    load_q,  load_d;   // N not yet sampled since power-on
    logic [NUM_RESETS-1:0]   rel_q,   rel_d;    // 1 = released
    logic                    busy_q,  busy_d;
    logic                    done_q,  done_d;

    logic [COUNT_WIDTH-1:0]  eff_len;
    logic [COUNT_WIDTH-1:0]  n_cur;
    logic [COUNT_WIDTH-1:0]  cnt_inc;
    logic [NUM_RESETS-1:0]   rel_next;

    assign eff_len = (i_assert_cycles != '0) ? i_assert_cycles
                                             : COUNT_WIDTH'(ASSERT_CYCLES);
    // Saturating increment: the counter never wraps.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + COUNT_WIDTH'(1);

    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        load_d   = load_q;
        rel_d    = rel_q;
        busy_d   = busy_q;
        done_d   = done_q;
        n_cur    = load_q ? eff_len : n_q;
        // Release register is a thermometer code filled from bit 0 upwards.
        rel_next = (rel_q << 1) | NUM_RESETS'(1);

        if (i_start) begin
            // Restart beats any terminal count seen in the same cycle.
            state_d = ST_ASSERT;
            cnt_d   = '0;
            n_d     = eff_len;
            load_d  = 1'b0;
            rel_d   = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    load_d = 1'b0;
                    n_d    = n_cur;
                    if (cnt_q == n_cur - COUNT_WIDTH'(1)) begin
                        cnt_d = '0;
                        if (ALL_AT_ONCE) begin
                            rel_d   = '1;
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            rel_d   = NUM_RESETS'(1);
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == STAG_LAST) begin
                        cnt_d = '0;
                        rel_d = rel_next;
                        if (&rel_next) begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_DONE: begin
                    // Hold until i_start or rst_n.
                end
                default: begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    rel_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // Local reset asserts asynchronously with rst_n, releases synchronously.
    always_ff @(posedge clk or negedge fsm_rst_n) begin
        if (!fsm_rst_n) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            n_q     <= COUNT_WIDTH'(ASSERT_CYCLES);
            load_q  <= 1'b1;
            rel_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            load_q  <= load_d;
            rel_q   <= rel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_reset_n = rel_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;

endmodule
